// File: rtl/ras_scan_ctrl_pkg.sv
// Shared types for the RAS scan controller.
// ras_t matches the frontend RAS top-of-stack entry (valid + return address).
package ras_scan_ctrl_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] ra;
    } ras_t;

    // Encoding is {is_ret, is_call}, so bit 0 means push and bit 1 means pop.
    typedef enum logic [1:0] {
        CFI_NONE  = 2'd0,
        CFI_CALL  = 2'd1,
        CFI_RET   = 2'd2,
        CFI_CORET = 2'd3
    } cfi_kind_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StOut
    } state_e;

    // Address of the instruction following a slot.
    function automatic logic [63:0] link_addr(input logic [63:0] pc, input logic rvc);
        return pc + (rvc ? 64'd2 : 64'd4);
    endfunction

endpackage

// File: rtl/ras_scan_ctrl_cfi_first_sel.sv
// cfi_first_sel: priority encoder returning the lowest set flag index.
module cfi_first_sel #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    flags_i,
    output logic [IdxW-1:0] idx_o,
    output logic            found_o
);

    // Scan from the top down so the lowest set index wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (flags_i[i]) begin
                idx_o   = IdxW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ras_scan_ctrl.sv
// ras_scan_ctrl: picks the first call/return slot of a fetch packet, predicts
// the return target from the RAS top and drives one RAS update per packet.
// Optional feature macro: RAS_SCAN_PERF_EN (return-miss counter).
module ras_scan_ctrl
    import ras_scan_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_PER_FETCH = 2,
    localparam int unsigned SlotW = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          fetch_valid_i,
    output logic                          fetch_ready_o,
    input  logic [INSTR_PER_FETCH-1:0]    slot_valid_i,
    input  logic [INSTR_PER_FETCH-1:0]    is_call_i,
    input  logic [INSTR_PER_FETCH-1:0]    is_ret_i,
    input  logic [INSTR_PER_FETCH-1:0]    is_rvc_i,
    input  logic [INSTR_PER_FETCH*64-1:0] slot_pc_i,
    input  ras_t                          ras_i,
    output logic                          ras_push_o,
    output logic                          ras_pop_o,
    output logic [63:0]                   ras_data_o,
    output logic                          pred_valid_o,
    input  logic                          pred_ready_i,
    output cfi_kind_t                     pred_kind_o,
    output logic [SlotW-1:0]              pred_slot_o,
    output logic [63:0]                   pred_target_o,
    output logic                          pred_target_valid_o,
    output logic [31:0]                   perf_ret_miss_o
);

    state_e state_q, state_d;

    logic [INSTR_PER_FETCH-1:0]       slot_valid_q, is_call_q, is_ret_q, is_rvc_q;
    logic [INSTR_PER_FETCH-1:0][63:0] slot_pc_q;

    cfi_kind_t   kind_q, scan_kind;
    logic [SlotW-1:0] slot_q, sel_idx;
    logic        sel_found;
    logic [63:0] link_q, target_q;
    logic        target_valid_q;
    logic        fetch_accept, handoff;

    assign fetch_accept = fetch_valid_i && fetch_ready_o;
    assign handoff      = (state_q == StOut) && pred_ready_i && !flush_i;

    cfi_first_sel #(
        .N    (INSTR_PER_FETCH),
        .IdxW (SlotW)
    ) u_first_sel (
        .flags_i (slot_valid_q & (is_call_q | is_ret_q)),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    // Kind of the selected slot; NONE when nothing is flagged.
    always_comb begin
        scan_kind = CFI_NONE;
        if (sel_found) begin
            scan_kind = cfi_kind_t'({is_ret_q[sel_idx], is_call_q[sel_idx]});
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fetch_valid_i && !flush_i) state_d = StScan;
            StScan:  state_d = flush_i ? StIdle : StOut;
            StOut: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (pred_ready_i) begin
                    state_d = fetch_valid_i ? StScan : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshakes and RAS ops; ops fire only on an unflushed handoff.
    always_comb begin
        fetch_ready_o = 1'b0;
        pred_valid_o  = 1'b0;
        ras_push_o    = 1'b0;
        ras_pop_o     = 1'b0;
        unique case (state_q)
            StIdle: fetch_ready_o = !flush_i;
            StScan: ;
            StOut: begin
                pred_valid_o  = 1'b1;
                fetch_ready_o = pred_ready_i && !flush_i;
                ras_push_o    = handoff && kind_q[0];
                ras_pop_o     = handoff && kind_q[1];
            end
            default: ;
        endcase
    end

    assign ras_data_o = ras_push_o ? link_q : '0;

    // Packet capture on accept, prediction capture in SCAN (RAS top sampled here).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q   <= '0;
            is_call_q      <= '0;
            is_ret_q       <= '0;
            is_rvc_q       <= '0;
            slot_pc_q      <= '0;
            kind_q         <= CFI_NONE;
            slot_q         <= '0;
            link_q         <= '0;
            target_q       <= '0;
            target_valid_q <= 1'b0;
        end else begin
            if (fetch_accept) begin
                slot_valid_q <= slot_valid_i;
                is_call_q    <= is_call_i;
                is_ret_q     <= is_ret_i;
                is_rvc_q     <= is_rvc_i;
                slot_pc_q    <= slot_pc_i;
            end
            if (state_q == StScan) begin
                kind_q         <= scan_kind;
                slot_q         <= sel_idx;
                link_q         <= link_addr(slot_pc_q[sel_idx], is_rvc_q[sel_idx]);
                target_q       <= scan_kind[1] ? ras_i.ra : 64'd0;
                target_valid_q <= scan_kind[1] ? ras_i.valid : 1'b0;
            end
        end
    end

    assign pred_kind_o         = kind_q;
    assign pred_slot_o         = slot_q;
    assign pred_target_o       = target_q;
    assign pred_target_valid_o = target_valid_q;

`ifdef RAS_SCAN_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of returns handed off with an invalid RAS top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (handoff && kind_q[1] && !target_valid_q && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_ret_miss_o = perf_q;
`else
    assign perf_ret_miss_o = '0;
`endif

endmodule

// File: doc/ras_scan_ctrl.md
# ras_scan_ctrl

Return-address-stack front-end controller sitting directly upstream of the frontend `ras`. It accepts predecoded fetch packets, finds the first call/return slot, and computes the link address. It samples the RAS top to produce a return-target prediction and drives `ras` push/pop exactly once per packet, when the downstream consumer accepts the prediction. The RAS therefore never sees duplicate or speculative-stall updates.

## Interface
- `INSTR_PER_FETCH`, default 2: slots per fetch packet (≥2).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; one clock, asynchronous, active-low.
- `flush_i` in 1: kill packet/prediction in flight (same flush that clears `ras`).
- `fetch_valid_i` in 1 / `fetch_ready_o` out 1: packet handshake.
- `slot_valid_i` in N: slot holds an instruction.
- `is_call_i` in N: slot links (rd = ra/t0).
- `is_ret_i` in N: slot returns (rs1 = ra/t0, rd ≠ link).
- `is_rvc_i` in N: slot is compressed.
- `slot_pc_i` in N×64: PC per slot, slot 0 in bits [63:0].
- `ras_i` in `ariane_pkg::ras_t`: current RAS top (`valid`, `ra`).
- `ras_push_o`, `ras_pop_o` out 1, `ras_data_o` out 64: RAS update.
- `pred_valid_o` out 1 / `pred_ready_i` in 1: prediction handshake.
- `pred_kind_o` out `cfi_kind_t` (2): NONE / CALL / RET / CORET.
- `pred_slot_o` out max(1,$clog2(N)): index of the selected slot.
- `pred_target_o` out 64: RAS-predicted return target.
- `pred_target_valid_o` out 1: RAS top was valid at sampling.
- `perf_ret_miss_o` out 32: counter of returns handed off with an invalid RAS top.

## Operation
- FSM states: IDLE, SCAN, OUT. Reset and flush both go to IDLE.
- IDLE:
  - `fetch_ready_o`=1.
  - On `fetch_valid_i`: latch all slot vectors, go to SCAN.
- SCAN (one cycle):
  - A slot is flagged when `slot_valid_i` and (`is_call_i` or `is_ret_i`). Select the lowest-index flagged slot; later slots are ignored.
  - Kind: NONE if no slot is flagged; CALL if call only; RET if ret only; CORET if both.
  - Link = slot PC + (rvc ? 2 : 4), modulo 2^64.
  - Sample `ras_i` into the target registers. Go to OUT.
- OUT:
  - `pred_valid_o`=1, all pred outputs stable until handshake.
  - Handshake (`pred_valid_o` && `pred_ready_i`) is combinational to RAS ops in the same cycle:
    - CALL: push with link.
    - RET: pop.
    - CORET: push and pop, data = link (RAS replaces top).
    - NONE: no op.
  - `fetch_ready_o` = `pred_ready_i`. An accepted new packet goes to SCAN, otherwise go to IDLE.
- For NONE and CALL, `pred_target_o`=0 and `pred_target_valid_o`=0. For RET/CORET, target = sampled `ras_i.ra` and target_valid = sampled `ras_i.valid`.
- A RET with an invalid top still pops (harmless underflow) and counts as a miss.
- `flush_i`:
  - Forces IDLE next cycle and suppresses `ras_push_o`/`ras_pop_o` and `fetch_ready_o` in the flush cycle, even if handshakes are high.
  - Does not clear `perf_ret_miss_o`.

## Timing
- Reset values: `fetch_ready_o`=1 (IDLE). `pred_valid_o`, `ras_push_o`, `ras_pop_o`=0. All data outputs 0. `perf_ret_miss_o`=0.
- Latency: packet accepted at cycle T → `pred_valid_o` at T+2.
- Throughput: one packet per 2 cycles with `pred_ready_i` held high.
- RAS consistency: the RAS op at handoff cycle T updates `ras` at the T+1 edge. The next SCAN (cycle T+1) samples the updated top, so back-to-back packets see each other's effects.
- A stall in OUT holds every output and issues no RAS op.
- Reset asserted mid-operation: immediate IDLE, no RAS op.

## Configuration
- `RAS_SCAN_PERF_EN` defined: `perf_ret_miss_o` increments on each RET/CORET handoff with target_valid=0 and saturates at 0xFFFF_FFFF.
- `RAS_SCAN_PERF_EN` undefined: the port exists but is tied to 0 and the counter is not instantiated.

## Structure
- `ariane_pkg` additions:
  - `cfi_kind_t` enum (CFI_NONE=0, CFI_CALL=1, CFI_RET=2, CFI_CORET=3).
  - The `ras_t` already present is reused.
- Sub-module `cfi_first_sel`: parameterised priority encoder over N flag bits, giving index + found. It is instantiated once in SCAN.

## Test plan
- Call, slot 1 rvc, PC 0x8000_0002: RAS op at handoff is push with data 0x8000_0004; kind CALL; slot 1.
- Ret with `ras_i`={1,0x1000}: pred target 0x1000, valid 1; `ras_pop_o` pulses once at handoff.
- Ret with an empty RAS, `pred_ready_i` low for 5 cycles: outputs held, no pop until ready; target_valid 0; perf counter 0→1 (macro on) or stays 0 (macro off).
- CORET at PC 0x2000 (4-byte): push and pop in the same cycle, data 0x2004, target = old top.
- Call packet immediately followed by a ret packet, ready high: the ret predicts 0x...+4 from the first packet's push, 2 cycles apart.
- Flush in OUT with `pred_ready_i`=1: no push/pop, IDLE next cycle; the next packet predicts from the unchanged top.
